// File: rtl/dreg_hist_pkg.sv
// Shared constants and helpers for the history register bank.
package dreg_hist_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_CHANNELS = 4;
  localparam int DEFAULT_DEPTH    = 4;

  // Width of a history index: ceil(log2(depth)), never less than one bit.
  function automatic int tapw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dreg_hist_chan.sv
// One channel: DEPTH-entry load history, fill counter, change flag, tap mux.
module dreg_hist_chan
  import dreg_hist_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int TAPW = tapw(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ch_clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic [TAPW-1:0]  tap_sel,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_tap,
  output logic             tap_valid,
  output logic             changed,
  output logic             full
);

  // TAPW+1 bits always hold the value DEPTH, so fill and tap indices share a width.
  localparam logic [TAPW:0] DEPTH_T = (TAPW+1)'(DEPTH);

  logic [WIDTH-1:0] hist [DEPTH];
  logic [TAPW:0]    fill;
  logic             changed_r;

  // History shift, fill count and change flag; clears beat loads.
  always_ff @(posedge clk) begin
    if (clr || ch_clr) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
      fill      <= '0;
      changed_r <= 1'b0;
    end else if (en) begin
      hist[0] <= d;
      for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
      if (fill != DEPTH_T) fill <= fill + 1'b1;
      // Empty history reads as zero, so a first load of zero is not a change.
      changed_r <= (d != hist[0]);
    end else begin
      changed_r <= 1'b0;
    end
  end

  // Tap mux; indices past the end of a non-power-of-2 history read as empty.
  always_comb begin
    q_tap     = '0;
    tap_valid = 1'b0;
    if ({1'b0, tap_sel} < DEPTH_T) begin
      q_tap     = hist[tap_sel];
      tap_valid = ({1'b0, tap_sel} < fill);
    end
  end

  assign q       = hist[0];
  assign changed = changed_r;
  assign full    = (fill == DEPTH_T);

endmodule

// File: rtl/dreg_hist_bank.sv
// Bank of CHANNELS independent clearable registers with load history.
module dreg_hist_bank
  import dreg_hist_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int DEPTH    = DEFAULT_DEPTH,
  localparam int TAPW    = tapw(DEPTH)
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       ch_clr,
  input  logic [TAPW-1:0]           tap_sel,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] q_tap,
  output logic [CHANNELS-1:0]       tap_valid,
  output logic [CHANNELS-1:0]       changed,
  output logic [CHANNELS-1:0]       full
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    dreg_hist_chan #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_chan (
      .clk       (clk),
      .clr       (clr),
      .ch_clr    (ch_clr[g]),
      .en        (en[g]),
      .d         (d[g*WIDTH +: WIDTH]),
      .tap_sel   (tap_sel),
      .q         (q[g*WIDTH +: WIDTH]),
      .q_tap     (q_tap[g*WIDTH +: WIDTH]),
      .tap_valid (tap_valid[g]),
      .changed   (changed[g]),
      .full      (full[g])
    );
  end

endmodule

// File: tb/tb_dreg_hist_bank.sv
// Bench for dreg_hist_bank: DEPTH=4 and DEPTH=3 instances on shared stimulus.
module tb_dreg_hist_bank;
  import dreg_hist_pkg::*;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int TW = tapw(4);

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clr = 1'b1;
  logic [CH*W-1:0]   d = '0;
  logic [CH-1:0]     en = '0;
  logic [CH-1:0]     ch_clr = '0;
  logic [TW-1:0]     tap_sel = '0;

  logic [CH*W-1:0] a_q, a_tap, b_q, b_tap;
  logic [CH-1:0]   a_tv, a_chg, a_full, b_tv, b_chg, b_full;

  dreg_hist_bank #(.WIDTH(W), .CHANNELS(CH), .DEPTH(4)) u_a (
    .clk(clk), .clr(clr), .d(d), .en(en), .ch_clr(ch_clr), .tap_sel(tap_sel),
    .q(a_q), .q_tap(a_tap), .tap_valid(a_tv), .changed(a_chg), .full(a_full));

  dreg_hist_bank #(.WIDTH(W), .CHANNELS(CH), .DEPTH(3)) u_b (
    .clk(clk), .clr(clr), .d(d), .en(en), .ch_clr(ch_clr), .tap_sel(tap_sel),
    .q(b_q), .q_tap(b_tap), .tap_valid(b_tv), .changed(b_chg), .full(b_full));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: each channel's history is a queue, newest at the front
  logic [W-1:0] hq [2][CH][$];
  logic [CH-1:0] mchg [2];

  function automatic int depth_of(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  task automatic model_step();
    logic [W-1:0] dc, old;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < CH; c++) begin
        dc = d[c*W +: W];
        if (clr || ch_clr[c]) begin
          hq[i][c].delete();
          mchg[i][c] = 1'b0;
        end else if (en[c]) begin
          old = (hq[i][c].size() > 0) ? hq[i][c][0] : '0;
          mchg[i][c] = (dc != old);
          hq[i][c].push_front(dc);
          if (hq[i][c].size() > depth_of(i)) void'(hq[i][c].pop_back());
        end else begin
          mchg[i][c] = 1'b0;
        end
      end
    end
  endtask

  task automatic model_expect(input int i, output logic [31:0] eq, output logic [31:0] et,
                              output logic [3:0] etv, output logic [3:0] echg,
                              output logic [3:0] efull);
    int sz;
    int t;
    t = int'(tap_sel);
    for (int c = 0; c < CH; c++) begin
      sz = hq[i][c].size();
      eq[c*W +: W] = (sz > 0) ? hq[i][c][0] : '0;
      et[c*W +: W] = (t < sz) ? hq[i][c][t] : '0;
      etv[c]       = (t < sz);
      efull[c]     = (sz == depth_of(i));
    end
    echg = mchg[i];
  endtask

  task automatic check_model();
    logic [31:0] eq, et;
    logic [3:0]  etv, echg, efull;
    model_expect(0, eq, et, etv, echg, efull);
    chk("a_q", a_q, eq);
    chk("a_q_tap", a_tap, et);
    chk("a_tap_valid", 32'(a_tv), 32'(etv));
    chk("a_changed", 32'(a_chg), 32'(echg));
    chk("a_full", 32'(a_full), 32'(efull));
    model_expect(1, eq, et, etv, echg, efull);
    chk("b_q", b_q, eq);
    chk("b_q_tap", b_tap, et);
    chk("b_tap_valid", 32'(b_tv), 32'(etv));
    chk("b_changed", 32'(b_chg), 32'(echg));
    chk("b_full", 32'(b_full), 32'(efull));
  endtask

  // driver tasks: one clock edge with model update, or a tap change only
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic set_tap(input int t);
    tap_sel = TW'(t);
    #1;
    check_model();
  endtask

  typedef struct {
    bit           tick;
    bit           clr;
    bit           en0;
    logic [W-1:0] d0;
    logic [1:0]   tap;
    logic [W-1:0] q;
    logic [W-1:0] qt;
    bit           tv;
    bit           chg;
    bit           full;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // channel 0 of the DEPTH=4 instance, hand-derived expectations
    tbl[0]  = '{1, 0, 1, 8'h11, 2'd1, 8'h11, 8'h00, 0, 1, 0};
    tbl[1]  = '{1, 0, 1, 8'h22, 2'd0, 8'h22, 8'h22, 1, 1, 0};
    tbl[2]  = '{1, 0, 1, 8'h33, 2'd2, 8'h33, 8'h11, 1, 1, 0};
    tbl[3]  = '{1, 0, 1, 8'h44, 2'd3, 8'h44, 8'h11, 1, 1, 1};
    tbl[4]  = '{1, 0, 1, 8'h55, 2'd0, 8'h55, 8'h55, 1, 1, 1};
    tbl[5]  = '{0, 0, 0, 8'h00, 2'd1, 8'h55, 8'h44, 1, 1, 1};
    tbl[6]  = '{0, 0, 0, 8'h00, 2'd2, 8'h55, 8'h33, 1, 1, 1};
    tbl[7]  = '{0, 0, 0, 8'h00, 2'd3, 8'h55, 8'h22, 1, 1, 1};
    tbl[8]  = '{1, 1, 0, 8'h00, 2'd3, 8'h00, 8'h00, 0, 0, 0};
    tbl[9]  = '{1, 0, 1, 8'hA5, 2'd0, 8'hA5, 8'hA5, 1, 1, 0};
    tbl[10] = '{1, 0, 0, 8'hFF, 2'd0, 8'hA5, 8'hA5, 1, 0, 0};
    tbl[11] = '{1, 0, 0, 8'hFF, 2'd0, 8'hA5, 8'hA5, 1, 0, 0};
    tbl[12] = '{1, 0, 0, 8'hFF, 2'd0, 8'hA5, 8'hA5, 1, 0, 0};
    tbl[13] = '{1, 0, 1, 8'hA5, 2'd1, 8'hA5, 8'hA5, 1, 0, 0};

    // reset: clr held two edges with random d/en
    for (int i = 0; i < 2; i++) begin
      clr = 1'b1;
      d   = $urandom;
      en  = 4'($urandom_range(0, 15));
      step();
    end
    chk("rst_q", a_q | b_q, 32'h0);
    chk("rst_q_tap", a_tap | b_tap, 32'h0);
    chk("rst_flags", 32'({a_tv, a_chg, a_full, b_tv, b_chg, b_full}), 32'h0);
    clr = 1'b0;
    en  = '0;

    // shift/tap and hold/change table
    for (int r = 0; r < 14; r++) begin
      clr     = tbl[r].clr;
      en      = {3'b000, tbl[r].en0};
      d       = {24'h0, tbl[r].d0};
      ch_clr  = '0;
      tap_sel = tbl[r].tap;
      if (tbl[r].tick) step();
      else begin
        #1;
        check_model();
      end
      chk($sformatf("tbl%0d_q", r), 32'(a_q[7:0]), 32'(tbl[r].q));
      chk($sformatf("tbl%0d_q_tap", r), 32'(a_tap[7:0]), 32'(tbl[r].qt));
      chk($sformatf("tbl%0d_tap_valid", r), 32'(a_tv[0]), 32'(tbl[r].tv));
      chk($sformatf("tbl%0d_changed", r), 32'(a_chg[0]), 32'(tbl[r].chg));
      chk($sformatf("tbl%0d_full", r), 32'(a_full[0]), 32'(tbl[r].full));
    end

    // isolation/priority: ch_clr on ch1 beats a same-cycle load
    clr = 1'b1; en = '0; step();
    clr = 1'b0; en = 4'b1111; d = 32'h04030201; step();
    ch_clr = 4'b0010; d = 32'h44332211; set_tap(0); step();
    ch_clr = 4'b0000; en = 4'b0000;
    chk("iso_q", a_q, 32'h44330011);
    chk("iso_changed", 32'(a_chg), 32'h0000000d);
    chk("iso_tap_valid0", 32'(a_tv), 32'h0000000d);
    set_tap(1);
    chk("iso_q_tap1", a_tap, 32'h04030001);
    chk("iso_full", 32'(a_full), 32'h0);

    // global clear mid-stream while full and loading
    en = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      step();
    end
    chk("mid_full", 32'(a_full), 32'h0000000f);
    set_tap(3);
    chk("np2_q_tap", b_tap, 32'h0);
    chk("np2_tap_valid", 32'(b_tv), 32'h0);
    clr = 1'b1; d = $urandom; step();
    chk("mid_clr_q", a_q, 32'h0);
    chk("mid_clr_full", 32'(a_full), 32'h0);
    clr = 1'b0; d = 32'h9abcdef1; step();
    chk("mid_reload_full", 32'(a_full), 32'h0);
    set_tap(0);
    chk("mid_tv0", 32'(a_tv), 32'h0000000f);
    set_tap(1);
    chk("mid_tv1", 32'(a_tv), 32'h0);

    // unknown data on held channels has no effect
    en = 4'b0000; d = 'x; step();
    chk("x_hold_q", a_q, 32'h9abcdef1);

    // randomized run against the queue model
    for (int n = 0; n < 10000; n++) begin
      d       = $urandom;
      en      = 4'($urandom_range(0, 15));
      ch_clr  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      clr     = ($urandom_range(0, 99) == 0);
      tap_sel = TW'($urandom_range(0, 3));
      step();
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
